// File: rtl/fp_pkg.sv
// Shared definitions for the small floating-point <-> linear converters.
//
// Holds the fixed field widths of the 1/3/4 sign/exponent/significand
// format, the width of the linear two's-complement result, and the
// state encoding used by the expander (and its linear-to-FP sibling).
package fp_pkg;

    localparam int EXP_W  = 3;   // exponent field, unsigned 0..7
    localparam int FRAC_W = 4;   // significand field, unsigned 0..15
    localparam int LIN_W  = 12;  // signed linear result
    localparam int MAG_W  = 11;  // unsigned magnitude, max 15 << 7 = 1920

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage : fp_pkg

// File: rtl/fp_expand.sv
// fp_expand -- expands a tiny sign/exponent/significand value into a
// 12-bit two's-complement linear value D = (S ? -1 : 1) * (F << E).
//
// The shift is done serially, one bit per clock, so a result takes
// E+1 clocks after the operand is accepted. A single operand is in
// flight at a time; the result is held until the consumer takes it.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   S          operand sign (1 = negative)
//   E          operand exponent, 0..7
//   F          operand significand, 0..15
//   in_valid   S/E/F valid this cycle
//   in_ready   block can accept an operand (combinational)
//   D          signed linear result, held until the next result
//   out_valid  D holds a completed, not yet taken result
//   out_ready  consumer takes D this cycle
module fp_expand
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             S,
    input  logic [EXP_W-1:0] E,
    input  logic [FRAC_W-1:0] F,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [LIN_W-1:0] D,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t             state;
    logic               sign;
    logic [EXP_W-1:0]   cnt;
    logic [MAG_W-1:0]   mag;
    logic signed [LIN_W-1:0] mag_s;

    // Magnitude is never more than 1920, so a zero sign bit on top makes
    // it a valid positive 12-bit value; negating zero yields zero, so no
    // negative zero can appear.
    assign mag_s    = signed'({1'b0, mag});

    // Ready is also gated by reset so nothing is offered as accepted
    // on an edge where reset wins.
    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            D         <= '0;
            out_valid <= 1'b0;
            mag       <= '0;
            cnt       <= '0;
            sign      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign  <= S;
                        cnt   <= E;
                        mag   <= MAG_W'(F);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        mag <= mag << 1;
                        cnt <= cnt - 1'b1;
                    end else begin
                        D         <= sign ? -mag_s : mag_s;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    // D is left untouched on handoff so the last result
                    // stays visible until the next one is produced.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : fp_expand
